decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/riscv_pkg.sv | 72 +++++++
 rtl/register_file.sv | 55 +++++
 rtl/decode_stage.sv | 158 +++++++++++++++
 tb/tb_decode_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, control encodings and the
// ID/EX pipeline bundle used by decode_stage.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4
  } imm_src_e;

  typedef struct packed {
    logic     reg_write;
    logic     mem_write;
    logic     jump;
    logic     branch;
    logic     alu_src;
    res_src_e result_src;
    alu_ctl_e alu_ctl;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } id_ex_t;

  // funct7[5] only selects sub for register-register add
  function automatic alu_ctl_e alu_decode(
    input logic [2:0] funct3,
    input logic       sub_sel
  );
    alu_ctl_e a;
    unique case (funct3)
      3'b000:  a = sub_sel ? ALU_SUB : ALU_ADD;
      3'b010:  a = ALU_SLT;
      3'b110:  a = ALU_OR;
      3'b111:  a = ALU_AND;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file, two async read ports, one write port on clk.
// Ports: clk, reset, we/wa/wd (write), ra1/ra2 -> rd1/rd2. Macro: REGFILE_BYPASS_EN.
module register_file
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (we && (wa != 5'd0)) begin
      regs_d[wa] = wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    rd1 = (ra1 == 5'd0) ? 32'd0 : regs_q[ra1];
    rd2 = (ra2 == 5'd0) ? 32'd0 : regs_q[ra2];
`ifdef REGFILE_BYPASS_EN
    // forward the in-flight writeback so decode sees the new value
    if (we && (wa != 5'd0) && (wa == ra1)) begin
      rd1 = wd;
    end
    if (we && (wa != 5'd0) && (wa == ra2)) begin
      rd2 = wd;
    end
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: control decode, immediate extend, regfile, ID/EX reg.
// Ports: D-side instr/PC, W-side writeback, FlushE; E-side registered outputs.
// Macro: REGFILE_BYPASS_EN (write-to-read forwarding in the register file).
module decode_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic [1:0]  ResultSrcE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D
);

  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [31:0] rd1_d;
  logic [31:0] rd2_d;
  logic [31:0] imm_d;
  ctrl_t       ctrl_d;
  imm_src_e    imm_src_d;
  id_ex_t      id_ex_d;
  id_ex_t      id_ex_q;

  assign op     = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign Rs1D   = InstrD[19:15];
  assign Rs2D   = InstrD[24:20];

  register_file u_rf (
    .clk   (clk),
    .reset (reset),
    .we    (RegWriteW),
    .wa    (RdW),
    .wd    (ResultW),
    .ra1   (Rs1D),
    .ra2   (Rs2D),
    .rd1   (rd1_d),
    .rd2   (rd2_d)
  );

  // unknown opcodes fall through with all-zero control: a bubble
  always_comb begin
    ctrl_d    = '0;
    imm_src_d = IMM_NONE;
    unique case (1'b1)
      (op == OP_LOAD): begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.result_src = RES_MEM;
        imm_src_d         = IMM_I;
      end
      (op == OP_STORE): begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        imm_src_d        = IMM_S;
      end
      (op == OP_RTYPE): begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_ctl   = alu_decode(funct3, InstrD[30]);
      end
      (op == OP_IALU): begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_ctl   = alu_decode(funct3, 1'b0);
        imm_src_d        = IMM_I;
      end
      (op == OP_BEQ): begin
        ctrl_d.branch  = 1'b1;
        ctrl_d.alu_ctl = ALU_SUB;
        imm_src_d      = IMM_B;
      end
      (op == OP_JAL): begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.jump       = 1'b1;
        ctrl_d.result_src = RES_PC4;
        imm_src_d         = IMM_J;
      end
      default: begin
        ctrl_d    = '0;
        imm_src_d = IMM_NONE;
      end
    endcase
  end

  always_comb begin
    unique case (imm_src_d)
      IMM_I: imm_d = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S: imm_d = {{20{InstrD[31]}}, InstrD[31:25],
                      InstrD[11:7]};
      IMM_B: imm_d = {{20{InstrD[31]}}, InstrD[7],
                      InstrD[30:25], InstrD[11:8], 1'b0};
      IMM_J: imm_d = {{12{InstrD[31]}}, InstrD[19:12],
                      InstrD[20], InstrD[30:21], 1'b0};
      default: imm_d = 32'd0;
    endcase
  end

  always_comb begin
    id_ex_d      = '0;
    if (!FlushE) begin
      id_ex_d.ctrl = ctrl_d;
      id_ex_d.rd1  = rd1_d;
      id_ex_d.rd2  = rd2_d;
      id_ex_d.imm  = imm_d;
      id_ex_d.pc   = PCD;
      id_ex_d.pc4  = PCPlus4D;
      id_ex_d.rs1  = Rs1D;
      id_ex_d.rs2  = Rs2D;
      id_ex_d.rd   = InstrD[11:7];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  assign RegWriteE   = id_ex_q.ctrl.reg_write;
  assign MemWriteE   = id_ex_q.ctrl.mem_write;
  assign JumpE       = id_ex_q.ctrl.jump;
  assign BranchE     = id_ex_q.ctrl.branch;
  assign ALUSrcE     = id_ex_q.ctrl.alu_src;
  assign ResultSrcE  = id_ex_q.ctrl.result_src;
  assign ALUControlE = id_ex_q.ctrl.alu_ctl;
  assign RD1E        = id_ex_q.rd1;
  assign RD2E        = id_ex_q.rd2;
  assign ImmExtE     = id_ex_q.imm;
  assign PCE         = id_ex_q.pc;
  assign PCPlus4E    = id_ex_q.pc4;
  assign Rs1E        = id_ex_q.rs1;
  assign Rs2E        = id_ex_q.rs2;
  assign RdE         = id_ex_q.rd;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized + directed bench for decode_stage against a behavioural model.
// Honors REGFILE_BYPASS_EN the same way as the design build.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, FlushE;
  logic [4:0]  RdW;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE, Rs1D, Rs2D;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] mregs [32];
  logic [9:0]  e_ctl;
  logic [31:0] e_rd1, e_rd2, e_imm, e_pc, e_pc4;
  logic [14:0] e_idx;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .RegWriteW(RegWriteW), .RdW(RdW),
    .ResultW(ResultW), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .Rs1D(Rs1D), .Rs2D(Rs2D)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] m_alu(input logic [2:0] f3,
                                       input logic sub);
    case (f3)
      3'd0:    return sub ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  // {regwrite,memwrite,jump,branch,alusrc,resultsrc[1:0],alu[2:0]}
  function automatic logic [9:0] m_ctl(input logic [31:0] ins);
    case (ins[6:0])
      7'h03: return 10'b1_0_0_0_1_01_000;
      7'h23: return 10'b0_1_0_0_1_00_000;
      7'h33: return {7'b1_0_0_0_0_00, m_alu(ins[14:12], ins[30])};
      7'h13: return {7'b1_0_0_0_1_00, m_alu(ins[14:12], 1'b0)};
      7'h63: return 10'b0_0_0_1_0_00_001;
      7'h6F: return 10'b1_0_1_0_0_10_000;
      default: return 10'd0;
    endcase
  endfunction

  // immediates built arithmetically from arithmetic shifts of the word
  function automatic logic [31:0] m_imm(input logic [31:0] ins);
    int s;
    s = int'(ins);
    case (ins[6:0])
      7'h03, 7'h13: return 32'(s >>> 20);
      7'h23: return 32'(((s >>> 25) <<< 5) + int'(ins[11:7]));
      7'h63: return 32'(((s >>> 31) <<< 12) + (int'(ins[7]) << 11)
                  + (int'(ins[30:25]) << 5) + (int'(ins[11:8]) << 1));
      7'h6F: return 32'(((s >>> 31) <<< 20) + (int'(ins[19:12]) << 12)
                  + (int'(ins[20]) << 11) + (int'(ins[30:21]) << 1));
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx,
      input logic wen, input logic [4:0] wa, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
    if (BYP && wen && wa == idx) return wd;
    return mregs[idx];
  endfunction

  task automatic clr_exp();
    e_ctl = '0; e_rd1 = '0; e_rd2 = '0; e_imm = '0;
    e_pc = '0; e_pc4 = '0; e_idx = '0;
  endtask

  task automatic check_e(input string t);
    chk({t, "_ctl"}, 32'({RegWriteE, MemWriteE, JumpE, BranchE,
        ALUSrcE, ResultSrcE, ALUControlE}), 32'(e_ctl));
    chk({t, "_rd1"}, RD1E, e_rd1);
    chk({t, "_rd2"}, RD2E, e_rd2);
    chk({t, "_imm"}, ImmExtE, e_imm);
    chk({t, "_pc"}, PCE, e_pc);
    chk({t, "_pc4"}, PCPlus4E, e_pc4);
    chk({t, "_idx"}, 32'({Rs1E, Rs2E, RdE}), 32'(e_idx));
  endtask

  // called at a negedge; returns at the next negedge after checking
  task automatic step(input string t, input logic [31:0] ins,
      input logic [31:0] pc, input logic wen, input logic [4:0] wa,
      input logic [31:0] wd, input logic fl);
    InstrD = ins; PCD = pc; PCPlus4D = pc + 32'd4;
    RegWriteW = wen; RdW = wa; ResultW = wd; FlushE = fl;
    #1;
    chk({t, "_rsD"}, 32'({Rs1D, Rs2D}), 32'({ins[19:15], ins[24:20]}));
    clr_exp();
    if (!fl) begin
      e_ctl = m_ctl(ins);
      e_rd1 = m_read(ins[19:15], wen, wa, wd);
      e_rd2 = m_read(ins[24:20], wen, wa, wd);
      e_imm = m_imm(ins);
      e_pc  = pc;
      e_pc4 = pc + 32'd4;
      e_idx = {ins[19:15], ins[24:20], ins[11:7]};
    end
    @(posedge clk);
    @(negedge clk);
    check_e(t);
    if (wen && wa != 5'd0) mregs[wa] = wd;
  endtask

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] ADD_X5   = 32'h0002_83B3;
  localparam logic [31:0] ADD_X0   = 32'h0000_0333;
  localparam logic [31:0] SW_I     = 32'hFE11_2E23;
  localparam logic [31:0] JAL_M8   = 32'hFF9F_F0EF;
  localparam logic [31:0] LW_I     = 32'h0042_A383;
  localparam logic [31:0] UNK_I    = 32'h1234_567F;

  initial begin
    logic [6:0]  ops [9];
    logic [31:0] ins;
    ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33; ops[3] = 7'h13;
    ops[4] = 7'h63; ops[5] = 7'h6F; ops[6] = 7'h7F; ops[7] = 7'h37;
    ops[8] = 7'h33;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    reset = 1'b1;
    InstrD = '0; PCD = '0; PCPlus4D = '0; RegWriteW = 1'b0;
    RdW = '0; ResultW = '0; FlushE = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clr_exp();
    check_e("reset");
    reset = 1'b0;

    // writeback then read
    step("wb5", NOP, 32'h100, 1'b1, 5'd5, 32'h1234, 1'b0);
    step("rd5", ADD_X5, 32'h104, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("req21_rd1", RD1E, 32'h1234);
    chk("req21_alu", 32'(ALUControlE), 32'd0);
    chk("req21_rw", 32'(RegWriteE), 32'd1);

    // same-cycle write and read of x5
    step("same", ADD_X5, 32'h108, 1'b1, 5'd5, 32'hAA, 1'b0);
    chk("req22_rd1", RD1E, BYP ? 32'hAA : 32'h1234);

    step("sw", SW_I, 32'h10C, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("req23_sw_imm", ImmExtE, 32'hFFFF_FFFC);
    chk("req23_sw_mw", 32'({MemWriteE, ALUSrcE}), 32'd3);

    step("jal", JAL_M8, 32'h110, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("req23_jal_imm", ImmExtE, 32'hFFFF_FFF8);
    chk("req23_jal_j", 32'({JumpE, ResultSrcE}), 32'b110);

    // flush still lets the regfile write happen
    step("flush", LW_I, 32'h114, 1'b1, 5'd9, 32'h99, 1'b1);
    chk("req24_flush", 32'({RegWriteE, MemWriteE, RdE}), 32'd0);
    chk("req24_pc", PCE, 32'd0);
    step("rd9", 32'h0004_8333, 32'h118, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("flush_wr", RD1E, 32'h99);

    step("wx0", NOP, 32'h11C, 1'b1, 5'd0, 32'hFFFF, 1'b0);
    step("rx0", ADD_X0, 32'h120, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("req25_x0", RD1E, 32'd0);

    step("unk", UNK_I, 32'h124, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("req25_unk", 32'({RegWriteE, MemWriteE, JumpE, BranchE,
        ALUSrcE, ResultSrcE, ALUControlE}), 32'd0);

    // reset mid-run with RegWriteE=1 and a pending writeback
    step("prerst", LW_I, 32'h128, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("req20_pre", 32'(RegWriteE), 32'd1);
    reset = 1'b1;
    RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'h55; FlushE = 1'b1;
    #1;
    clr_exp();
    check_e("rst_async");
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    @(negedge clk);
    check_e("rst_hold");
    reset = 1'b0;
    step("postrst", ADD_X5, 32'h200, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("req20_x5", RD1E, 32'd0);

    for (int n = 0; n < 400; n++) begin
      ins = ($urandom & 32'hFFFF_FF80)
          | 32'(ops[$urandom_range(0, 8)]);
      step("rnd", ins, $urandom & 32'hFFFF_FFFC,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           $urandom, ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
